// File: rtl/button_conditioner.sv
// button_conditioner: debounces a synchronized button/switch bus.
// A shared sample timer produces a periodic tick; each bit owns a saturating
// counter that must see PULSE_CNT_MAX ticks while continuously high before the
// bit is declared pressed. Any low cycle clears the counter at once, so a
// release is reported immediately while a press is filtered. Single-cycle
// rise/fall pulses are derived from the debounced level.
// Outputs are plain levels and one-cycle pulses; there is no handshake, so a
// consumer must sample rise_pulse/fall_pulse on every clock.
module button_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sync_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int SMP_W = $clog2(SAMPLE_CNT_MAX);
  localparam int SAT_W = $clog2(PULSE_CNT_MAX + 1);

  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [SAT_W-1:0] SAT_FULL = SAT_W'(PULSE_CNT_MAX);

  logic [SMP_W-1:0] smp_cnt_q;
  logic [SMP_W-1:0] smp_cnt_d;
  logic             tick;

  logic [SAT_W-1:0] sat_q [WIDTH];
  logic [SAT_W-1:0] sat_d [WIDTH];

  logic [WIDTH-1:0] prev_q;

  // Shared sample timer: tick marks the last cycle of each sample period.
  always_comb begin
    tick      = (smp_cnt_q == SMP_LAST);
    smp_cnt_d = tick ? '0 : smp_cnt_q + 1'b1;
  end

  // Sample timer register; reset restarts the tick phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cnt_q <= '0;
    end else begin
      smp_cnt_q <= smp_cnt_d;
    end
  end

  // Per-bit counter next state: a low input clears (wins over tick),
  // otherwise a tick advances the count until it saturates.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      sat_d[i] = sat_q[i];
      if (!sync_signal[i]) begin
        sat_d[i] = '0;
      end else if (tick && (sat_q[i] < SAT_FULL)) begin
        sat_d[i] = sat_q[i] + 1'b1;
      end
    end
  end

  // Per-bit saturating counter registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst) begin
        sat_q[i] <= '0;
      end else begin
        sat_q[i] <= sat_d[i];
      end
    end
  end

  // Debounced level is decoded from the counters only, never from the input.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      debounced_signal[i] = (sat_q[i] == SAT_FULL);
    end
  end

  // Previous debounced level, used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= debounced_signal;
    end
  end

  // One-cycle pulses on each debounced transition.
  always_comb begin
    rise_pulse = debounced_signal & ~prev_q;
    fall_pulse = ~debounced_signal & prev_q;
  end

endmodule
